// File: rtl/pif_led_sequencer.sv
// rtl/pif_led_sequencer.sv - register-programmed 4-step LED pattern sequencer
module pif_led_sequencer #(
    parameter int CLK_DIV   = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 xclk,
    input  logic                 sys_rst,
    input  logic                 wr_stb,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data,
    input  logic                 red_in,
    input  logic                 green_in,
    output logic                 led_r,
    output logic                 led_g,
    output logic                 busy,
    output logic [1:0]           step_idx,
    output logic                 done
);

    localparam int              PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic            loop_q, loop_d;
    logic [1:0]      mode_q, mode_d;
    logic [5:0]      rem_q, rem_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [7:0]      tbl_q [4];
    logic [7:0]      tbl_d [4];
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            led_r_q, led_r_d;
    logic            led_g_q, led_g_d;
    logic [7:0]      rd_data_q, rd_data_d;

    logic            ctrl_wr;
    logic            start_req;
    logic            stop_req;
    logic            adv;
    logic [1:0]      nxt_mode;
    logic            nxt_lit;

    // Next-state: register writes, step scheduling, and LED/readback lookahead
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        loop_d    = loop_q;
        mode_d    = mode_q;
        rem_d     = rem_q;
        pre_d     = pre_q;
        tbl_d     = tbl_q;
        done_d    = 1'b0;
        adv       = 1'b0;
        nxt_mode  = 2'b00;
        nxt_lit   = 1'b0;
        led_r_d   = 1'b0;
        led_g_d   = 1'b0;
        rd_data_d = 8'h00;

        ctrl_wr   = wr_stb && (wr_addr == '0);
        start_req = ctrl_wr && wr_data[0];
        stop_req  = ctrl_wr && wr_data[2];

        if (ctrl_wr) begin
            loop_d = wr_data[1];
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_stb && (wr_addr == ADDR_BITS'(i + 1))) begin
                tbl_d[i] = wr_data;
            end
        end

        case (state_q)
            S_LOAD: begin
                // The working copy is taken here so later table writes do not disturb this step
                mode_d = tbl_q[step_q][7:6];
                rem_d  = tbl_q[step_q][5:0];
                pre_d  = '0;
                if (tbl_q[step_q][5:0] == 6'd0) begin
                    adv = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        adv = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: ;
        endcase

        // End-of-table decision sees a loop bit written in this same cycle
        if (adv) begin
            if (step_q != 2'd3) begin
                step_d  = step_q + 2'd1;
                state_d = S_LOAD;
            end else if (loop_d) begin
                step_d  = 2'd0;
                state_d = S_LOAD;
            end else begin
                step_d  = 2'd0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        if (start_req) begin
            state_d = S_LOAD;
            step_d  = 2'd0;
            pre_d   = '0;
            done_d  = 1'b0;
        end
        if (stop_req) begin
            state_d = S_IDLE;
            step_d  = 2'd0;
            pre_d   = '0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);

        // LEDs cover the whole step including its LOAD cycle; skipped steps stay dark
        case (state_d)
            S_LOAD: begin
                nxt_mode = tbl_d[step_d][7:6];
                nxt_lit  = (tbl_d[step_d][5:0] != 6'd0);
            end
            S_RUN: begin
                nxt_mode = mode_d;
                nxt_lit  = 1'b1;
            end
            default: ;
        endcase

        if (nxt_lit) begin
            case (nxt_mode)
                2'b01: begin
                    led_r_d = red_in;
                    led_g_d = green_in;
                end
                2'b10: begin
                    led_r_d = red_in;
                    led_g_d = red_in;
                end
                2'b11: begin
                    led_r_d = 1'b1;
                    led_g_d = 1'b1;
                end
                default: ;
            endcase
        end

        case (rd_addr)
            ADDR_BITS'(0): rd_data_d = {6'b0, loop_q, 1'b0};
            ADDR_BITS'(1): rd_data_d = tbl_q[0];
            ADDR_BITS'(2): rd_data_d = tbl_q[1];
            ADDR_BITS'(3): rd_data_d = tbl_q[2];
            ADDR_BITS'(4): rd_data_d = tbl_q[3];
            ADDR_BITS'(5): rd_data_d = {busy_q, loop_q, 4'b0, step_q};
            default:       rd_data_d = 8'h00;
        endcase
    end

    // State and registered outputs, cleared by the synchronous reset
    always_ff @(posedge xclk) begin
        if (!sys_rst) begin
            state_q   <= S_IDLE;
            step_q    <= 2'd0;
            loop_q    <= 1'b0;
            mode_q    <= 2'b00;
            rem_q     <= 6'd0;
            pre_q     <= '0;
            tbl_q     <= '{default: 8'h00};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_r_q   <= 1'b0;
            led_g_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            loop_q    <= loop_d;
            mode_q    <= mode_d;
            rem_q     <= rem_d;
            pre_q     <= pre_d;
            tbl_q     <= tbl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign led_r    = led_r_q;
    assign led_g    = led_g_q;
    assign busy     = busy_q;
    assign step_idx = step_q;
    assign done     = done_q;

endmodule
